// File: rtl/ace_if.sv
// ACE bus bundle: AXI4 read/write channels, RACK/WACK, and the AC/CR/CD snoop channels.
// The m modport is the cache-side master view.
interface ace_if #(
    parameter int ACE_XDATA_WIDTH  = 256,
    parameter int ACE_AXADDR_WIDTH = 32,
    parameter int ACE_ID_WIDTH     = 4
);
    logic [ACE_ID_WIDTH-1:0]      awid;
    logic [ACE_AXADDR_WIDTH-1:0]  awaddr;
    logic [7:0]                   awlen;
    logic [2:0]                   awsize;
    logic [1:0]                   awburst;
    logic                         awlock;
    logic [3:0]                   awcache;
    logic [2:0]                   awprot;
    logic [3:0]                   awqos;
    logic [3:0]                   awregion;
    logic                         awuser;
    logic [2:0]                   awsnoop;
    logic [1:0]                   awdomain;
    logic [1:0]                   awbar;
    logic                         awvalid;
    logic                         awready;

    logic [ACE_XDATA_WIDTH-1:0]   wdata;
    logic [ACE_XDATA_WIDTH/8-1:0] wstrb;
    logic                         wlast;
    logic                         wuser;
    logic                         wvalid;
    logic                         wready;

    logic [ACE_ID_WIDTH-1:0]      bid;
    logic [1:0]                   bresp;
    logic                         bvalid;
    logic                         bready;

    logic [ACE_ID_WIDTH-1:0]      arid;
    logic [ACE_AXADDR_WIDTH-1:0]  araddr;
    logic [7:0]                   arlen;
    logic [2:0]                   arsize;
    logic [1:0]                   arburst;
    logic                         arlock;
    logic [3:0]                   arcache;
    logic [2:0]                   arprot;
    logic [3:0]                   arqos;
    logic [3:0]                   arregion;
    logic                         aruser;
    logic [3:0]                   arsnoop;
    logic [1:0]                   ardomain;
    logic [1:0]                   arbar;
    logic                         arvalid;
    logic                         arready;

    logic [ACE_ID_WIDTH-1:0]      rid;
    logic [ACE_XDATA_WIDTH-1:0]   rdata;
    logic [3:0]                   rresp;
    logic                         rlast;
    logic                         rvalid;
    logic                         rready;

    logic                         rack;
    logic                         wack;

    logic                         acvalid;
    logic                         acready;
    logic [ACE_AXADDR_WIDTH-1:0]  acaddr;
    logic [3:0]                   acsnoop;
    logic [2:0]                   acprot;

    logic                         crvalid;
    logic                         crready;
    logic [4:0]                   crresp;

    logic                         cdvalid;
    logic                         cdready;
    logic [ACE_XDATA_WIDTH-1:0]   cddata;
    logic                         cdlast;

    modport m (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awqos, awregion, awuser, awsnoop, awdomain, awbar, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wuser, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arqos, arregion, aruser, arsnoop, ardomain, arbar, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready, rack, wack,
        input  acvalid, acaddr, acsnoop, acprot,
        output acready,
        output crvalid, crresp,
        input  crready,
        output cdvalid, cddata, cdlast,
        input  cdready
    );
endinterface

// File: rtl/ace_line_port.sv
// Cache-side ACE master: turns one-line refills and victim writebacks into single-beat
// ACE transactions with RACK/WACK completion; snoop channels pass straight through.
module ace_line_port #(
    parameter int ACE_XDATA_WIDTH  = 256,
    parameter int ACE_AXADDR_WIDTH = 32,
    parameter int ACE_ID_WIDTH     = 4,
    parameter int TXN_ID           = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    ace_if.m                            ace,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [1:0]                  req_op,
    input  logic [ACE_AXADDR_WIDTH-1:0] req_addr,
    input  logic [ACE_XDATA_WIDTH-1:0]  req_wdata,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [ACE_XDATA_WIDTH-1:0]  resp_rdata,
    output logic                        resp_shared,
    output logic                        resp_dirty,
    output logic                        resp_err,
    output logic                        snp_acvalid,
    output logic [ACE_AXADDR_WIDTH-1:0] snp_acaddr,
    output logic [3:0]                  snp_acsnoop,
    output logic [2:0]                  snp_acprot,
    input  logic                        snp_acready,
    input  logic                        snp_crvalid,
    input  logic [4:0]                  snp_crresp,
    input  logic                        snp_cdvalid,
    input  logic [ACE_XDATA_WIDTH-1:0]  snp_cddata,
    input  logic                        snp_cdlast,
    output logic                        snp_crready,
    output logic                        snp_cdready,
    output logic [2:0]                  dbg_state
);
    localparam int                          BYTE_LSB  = $clog2(ACE_XDATA_WIDTH / 8);
    localparam logic [2:0]                  AXSIZE    = 3'(BYTE_LSB);
    localparam logic [ACE_AXADDR_WIDTH-1:0] LINE_MASK = ~ACE_AXADDR_WIDTH'((1 << BYTE_LSB) - 1);
    localparam logic [ACE_ID_WIDTH-1:0]     ID        = ACE_ID_WIDTH'(TXN_ID);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_RACK = 3'd3,
        S_AW   = 3'd4,
        S_B    = 3'd5,
        S_WACK = 3'd6,
        S_RESP = 3'd7
    } state_t;

    state_t                        state;
    logic                          unique_q;
    logic [ACE_AXADDR_WIDTH-1:0]   addr_q;
    logic [ACE_XDATA_WIDTH-1:0]    wdata_q;
    logic                          arvalid_q;
    logic                          rready_q;
    logic                          rack_q;
    logic                          awvalid_q;
    logic                          wvalid_q;
    logic                          bready_q;
    logic                          wack_q;
    logic                          aw_done;
    logic                          w_done;
    logic                          aw_hs;
    logic                          w_hs;
    logic [ACE_AXADDR_WIDTH-1:0]   line_addr;

    // Every channel transfers on the edge where valid and ready are both high; a raised
    // valid is held, with its payload stable, until that edge, and ready may wait on valid.
    assign aw_hs     = awvalid_q & ace.awready;
    assign w_hs      = wvalid_q & ace.wready;
    assign line_addr = addr_q & LINE_MASK;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_shared <= 1'b0;
            resp_dirty  <= 1'b0;
            resp_err    <= 1'b0;
            unique_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rack_q      <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            wack_q      <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        unique_q    <= req_op[0];
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        resp_rdata  <= '0;
                        resp_shared <= 1'b0;
                        resp_dirty  <= 1'b0;
                        resp_err    <= 1'b0;
                        case (req_op)
                            2'd0, 2'd1: begin
                                arvalid_q <= 1'b1;
                                state     <= S_AR;
                            end
                            2'd2: begin
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                aw_done   <= 1'b0;
                                w_done    <= 1'b0;
                                state     <= S_AW;
                            end
                            default: begin
                                // Reserved op completes with an error and never touches the bus.
                                resp_err   <= 1'b1;
                                resp_valid <= 1'b1;
                                state      <= S_RESP;
                            end
                        endcase
                    end
                end
                S_AR: begin
                    if (ace.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= S_R;
                    end
                end
                S_R: begin
                    if (ace.rvalid) begin
                        rready_q    <= 1'b0;
                        resp_rdata  <= ace.rdata;
                        resp_shared <= ace.rresp[3];
                        resp_dirty  <= ace.rresp[2];
                        resp_err    <= |ace.rresp[1:0];
                        rack_q      <= 1'b1;
                        state       <= S_RACK;
                    end
                end
                S_RACK: begin
                    rack_q     <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_AW: begin
                    // AW and W retire independently; either may finish first or both together.
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bready_q <= 1'b1;
                        state    <= S_B;
                    end
                end
                S_B: begin
                    if (ace.bvalid) begin
                        bready_q <= 1'b0;
                        resp_err <= |ace.bresp;
                        wack_q   <= 1'b1;
                        state    <= S_WACK;
                    end
                end
                S_WACK: begin
                    wack_q     <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ace.awid     = ID;
    assign ace.awaddr   = line_addr;
    assign ace.awlen    = 8'd0;
    assign ace.awsize   = AXSIZE;
    assign ace.awburst  = 2'b01;
    assign ace.awlock   = 1'b0;
    assign ace.awcache  = 4'b0011;
    assign ace.awprot   = 3'd0;
    assign ace.awqos    = 4'd0;
    assign ace.awregion = 4'd0;
    assign ace.awuser   = 1'b0;
    assign ace.awsnoop  = 3'b011;
    assign ace.awdomain = 2'b01;
    assign ace.awbar    = 2'b00;
    assign ace.awvalid  = awvalid_q;

    assign ace.wdata    = wdata_q;
    assign ace.wstrb    = '1;
    assign ace.wlast    = 1'b1;
    assign ace.wuser    = 1'b0;
    assign ace.wvalid   = wvalid_q;
    assign ace.bready   = bready_q;

    assign ace.arid     = ID;
    assign ace.araddr   = line_addr;
    assign ace.arlen    = 8'd0;
    assign ace.arsize   = AXSIZE;
    assign ace.arburst  = 2'b01;
    assign ace.arlock   = 1'b0;
    assign ace.arcache  = 4'b0011;
    assign ace.arprot   = 3'd0;
    assign ace.arqos    = 4'd0;
    assign ace.arregion = 4'd0;
    assign ace.aruser   = 1'b0;
    assign ace.arsnoop  = unique_q ? 4'b0111 : 4'b0001;
    assign ace.ardomain = 2'b01;
    assign ace.arbar    = 2'b00;
    assign ace.arvalid  = arvalid_q;
    assign ace.rready   = rready_q;
    assign ace.rack     = rack_q;
    assign ace.wack     = wack_q;

    // Snoop path is wires only; the cache's snoop port owns all snoop flow control.
    assign snp_acvalid  = ace.acvalid;
    assign snp_acaddr   = ace.acaddr;
    assign snp_acsnoop  = ace.acsnoop;
    assign snp_acprot   = ace.acprot;
    assign ace.acready  = snp_acready;
    assign ace.crvalid  = snp_crvalid;
    assign ace.crresp   = snp_crresp;
    assign ace.cdvalid  = snp_cdvalid;
    assign ace.cddata   = snp_cddata;
    assign ace.cdlast   = snp_cdlast;
    assign snp_crready  = ace.crready;
    assign snp_cdready  = ace.cdready;

    logic unused_ok;
    assign unused_ok = ^{ace.rid, ace.rlast, ace.bid};
endmodule

// File: tb/tb_ace_line_port.sv
// Bench for ace_line_port: scenario tasks drive a hand-modelled ACE slave and check each
// step inline; expected completions are queued and compared when resp_valid/resp_ready meet.
module tb_ace_line_port;
    localparam int XW = 256;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam logic [AW-1:0] LMASK = 32'hFFFF_FFE0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ace_if #(.ACE_XDATA_WIDTH(XW), .ACE_AXADDR_WIDTH(AW), .ACE_ID_WIDTH(IW)) ace ();

    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'd0;
    logic [AW-1:0] req_addr = '0;
    logic [XW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [XW-1:0] resp_rdata;
    logic          resp_shared;
    logic          resp_dirty;
    logic          resp_err;
    logic          snp_acvalid;
    logic [AW-1:0] snp_acaddr;
    logic [3:0]    snp_acsnoop;
    logic [2:0]    snp_acprot;
    logic          snp_acready = 1'b0;
    logic          snp_crvalid = 1'b0;
    logic [4:0]    snp_crresp = '0;
    logic          snp_cdvalid = 1'b0;
    logic [XW-1:0] snp_cddata = '0;
    logic          snp_cdlast = 1'b0;
    logic          snp_crready;
    logic          snp_cdready;
    logic [2:0]    dbg_state;

    ace_line_port #(
        .ACE_XDATA_WIDTH(XW), .ACE_AXADDR_WIDTH(AW), .ACE_ID_WIDTH(IW), .TXN_ID(0)
    ) dut (
        .clk(clk), .rst(rst), .ace(ace),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_shared(resp_shared), .resp_dirty(resp_dirty), .resp_err(resp_err),
        .snp_acvalid(snp_acvalid), .snp_acaddr(snp_acaddr), .snp_acsnoop(snp_acsnoop),
        .snp_acprot(snp_acprot), .snp_acready(snp_acready),
        .snp_crvalid(snp_crvalid), .snp_crresp(snp_crresp),
        .snp_cdvalid(snp_cdvalid), .snp_cddata(snp_cddata), .snp_cdlast(snp_cdlast),
        .snp_crready(snp_crready), .snp_cdready(snp_cdready),
        .dbg_state(dbg_state)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [XW+2:0] exp_q[$];
    logic watch_ax = 1'b0;
    logic ax_seen = 1'b0;

    // Scoreboard: one expected completion popped per resp handshake.
    always @(negedge clk) begin
        logic [XW+2:0] got;
        logic [XW+2:0] want;
        if (watch_ax && (ace.arvalid === 1'b1 || ace.awvalid === 1'b1)) ax_seen = 1'b1;
        if (!rst && resp_valid === 1'b1 && resp_ready === 1'b1) begin
            got = {resp_rdata, resp_shared, resp_dirty, resp_err};
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL resp_unexpected: got %h with no expected entry", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) $display("FAIL resp_payload: got %h want %h", got, want);
                else pass_cnt++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XW-1:0] rand_line();
        logic [XW-1:0] v;
        for (int i = 0; i < XW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic issue_req(input logic [1:0] op, input logic [AW-1:0] addr, input logic [XW-1:0] wd);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        while (req_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL req_accept: req_ready=%b want 1 within 50 cycles", req_ready);
        else pass_cnt++;
        step();
        req_valid = 1'b0;
        req_addr  = ~addr;
        req_wdata = ~wd;
    endtask

    task automatic drain_resp();
        int n = 0;
        resp_ready = 1'b1;
        while (resp_valid === 1'b1 && n < 20) begin
            step();
            n++;
        end
        total_cnt++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL resp_drain: resp_valid=%b req_ready=%b want 0/1", resp_valid, req_ready);
        else pass_cnt++;
    endtask

    // Ends in RESP with resp_valid visible; caller decides when resp_ready rises.
    task automatic run_read(input logic [1:0] op, input logic [AW-1:0] addr, input logic [XW-1:0] data,
                            input logic [3:0] rr, input int ar_wait);
        logic [AW-1:0] ea;
        logic [3:0] esnoop;
        ea = addr & LMASK;
        esnoop = (op == 2'd1) ? 4'b0111 : 4'b0001;
        exp_q.push_back({data, rr[3], rr[2], |rr[1:0]});
        issue_req(op, addr, '0);
        total_cnt++;
        if ({ace.arsnoop, ace.arlen, ace.arsize, ace.arburst, ace.ardomain, ace.arcache, ace.arid}
            !== {esnoop, 8'd0, 3'd5, 2'b01, 2'b01, 4'b0011, 4'd0})
            $display("FAIL ar_fields: snoop=%b len=%0d size=%0d burst=%b dom=%b cache=%b id=%0d want snoop=%b len=0 size=5 burst=01 dom=01 cache=0011 id=0",
                     ace.arsnoop, ace.arlen, ace.arsize, ace.arburst, ace.ardomain, ace.arcache, ace.arid, esnoop);
        else pass_cnt++;
        for (int i = 0; i <= ar_wait; i++) begin
            total_cnt++;
            if (ace.arvalid !== 1'b1 || ace.araddr !== ea)
                $display("FAIL ar_hold: cycle %0d arvalid=%b araddr=%h want 1/%h", i, ace.arvalid, ace.araddr, ea);
            else pass_cnt++;
            ace.arready = (i == ar_wait);
            step();
        end
        ace.arready = 1'b0;
        total_cnt++;
        if (ace.rready !== 1'b1 || ace.arvalid !== 1'b0)
            $display("FAIL r_wait: rready=%b arvalid=%b want 1/0", ace.rready, ace.arvalid);
        else pass_cnt++;
        ace.rvalid = 1'b1;
        ace.rdata  = data;
        ace.rresp  = rr;
        ace.rlast  = 1'b1;
        step();
        ace.rvalid = 1'b0;
        ace.rdata  = ~data;
        total_cnt++;
        if (ace.rack !== 1'b1 || resp_valid !== 1'b0 || ace.rready !== 1'b0)
            $display("FAIL rack_rise: rack=%b resp_valid=%b rready=%b want 1/0/0", ace.rack, resp_valid, ace.rready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (ace.rack !== 1'b0 || resp_valid !== 1'b1)
            $display("FAIL rack_fall: rack=%b resp_valid=%b want 0/1", ace.rack, resp_valid);
        else pass_cnt++;
    endtask

    task automatic run_write(input logic [AW-1:0] addr, input logic [XW-1:0] data,
                             input int aw_delay, input int w_delay, input logic [1:0] br);
        logic [AW-1:0] ea;
        int last;
        ea = addr & LMASK;
        last = (aw_delay > w_delay) ? aw_delay : w_delay;
        exp_q.push_back({{XW{1'b0}}, 1'b0, 1'b0, |br});
        issue_req(2'd2, addr, data);
        total_cnt++;
        if ({ace.awaddr, ace.awsnoop, ace.awlen, ace.awsize, ace.awdomain, ace.awid, ace.wstrb, ace.wlast}
            !== {ea, 3'b011, 8'd0, 3'd5, 2'b01, 4'd0, {(XW/8){1'b1}}, 1'b1})
            $display("FAIL aw_fields: addr=%h snoop=%b len=%0d size=%0d dom=%b id=%0d wstrb=%h wlast=%b want addr=%h snoop=011",
                     ace.awaddr, ace.awsnoop, ace.awlen, ace.awsize, ace.awdomain, ace.awid, ace.wstrb, ace.wlast, ea);
        else pass_cnt++;
        total_cnt++;
        if (ace.wdata !== data) $display("FAIL w_data: got %h want %h", ace.wdata, data);
        else pass_cnt++;
        for (int c = 0; c <= last; c++) begin
            total_cnt++;
            if (ace.awvalid !== (c <= aw_delay) || ace.wvalid !== (c <= w_delay))
                $display("FAIL aw_w_order: cycle %0d awvalid=%b wvalid=%b want %b/%b",
                         c, ace.awvalid, ace.wvalid, c <= aw_delay, c <= w_delay);
            else pass_cnt++;
            ace.awready = (c == aw_delay);
            ace.wready  = (c == w_delay);
            step();
        end
        ace.awready = 1'b0;
        ace.wready  = 1'b0;
        total_cnt++;
        if (ace.bready !== 1'b1 || ace.awvalid !== 1'b0 || ace.wvalid !== 1'b0)
            $display("FAIL b_wait: bready=%b awvalid=%b wvalid=%b want 1/0/0", ace.bready, ace.awvalid, ace.wvalid);
        else pass_cnt++;
        ace.bvalid = 1'b1;
        ace.bresp  = br;
        step();
        ace.bvalid = 1'b0;
        ace.bresp  = 2'b00;
        total_cnt++;
        if (ace.wack !== 1'b1 || ace.bready !== 1'b0 || resp_valid !== 1'b0)
            $display("FAIL wack_rise: wack=%b bready=%b resp_valid=%b want 1/0/0", ace.wack, ace.bready, resp_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (ace.wack !== 1'b0 || resp_valid !== 1'b1)
            $display("FAIL wack_fall: wack=%b resp_valid=%b want 0/1", ace.wack, resp_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        total_cnt++;
        if ({req_ready, resp_valid, ace.arvalid, ace.awvalid, ace.wvalid, ace.rack, ace.wack} !== 7'd0)
            $display("FAIL reset_outputs: req_ready=%b resp_valid=%b arvalid=%b awvalid=%b wvalid=%b rack=%b wack=%b want all 0",
                     req_ready, resp_valid, ace.arvalid, ace.awvalid, ace.wvalid, ace.rack, ace.wack);
        else pass_cnt++;
        total_cnt++;
        if (dbg_state !== 3'd0 || resp_rdata !== '0) $display("FAIL reset_state: state=%0d rdata=%h want 0/0", dbg_state, resp_rdata);
        else pass_cnt++;
        rst = 1'b0;
        step();
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_release: req_ready=%b want 1", req_ready);
        else pass_cnt++;
    endtask

    task automatic test_read_shared();
        resp_ready = 1'b1;
        run_read(2'd0, 32'h0000_1234, rand_line(), 4'b1000, 0);
        drain_resp();
    endtask

    task automatic test_read_unique_backpressure();
        resp_ready = 1'b1;
        run_read(2'd1, 32'h8000_0047, rand_line(), 4'b0100, 5);
        drain_resp();
        run_read(2'd1, 32'h0000_3FFF, rand_line(), 4'b0010, 2);
        drain_resp();
    endtask

    task automatic test_writeback();
        resp_ready = 1'b1;
        run_write(32'h0001_0010, rand_line(), 3, 0, 2'b00);
        drain_resp();
        run_write(32'h0002_0000, rand_line(), 0, 0, 2'b00);
        drain_resp();
        run_write(32'h0003_0021, rand_line(), 1, 2, 2'b10);
        drain_resp();
    endtask

    task automatic test_resp_backpressure();
        logic [XW-1:0] d;
        d = rand_line();
        resp_ready = 1'b0;
        run_read(2'd0, 32'h0000_5000, d, 4'b1000, 0);
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_addr  = 32'h0000_6000;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (resp_valid !== 1'b1 || resp_rdata !== d || resp_shared !== 1'b1 || resp_err !== 1'b0 ||
                req_ready !== 1'b0 || dbg_state !== 3'd7)
                $display("FAIL resp_stall: cycle %0d valid=%b shared=%b err=%b req_ready=%b state=%0d want 1/1/0/0/7",
                         i, resp_valid, resp_shared, resp_err, req_ready, dbg_state);
            else pass_cnt++;
            step();
        end
        req_valid = 1'b0;
        drain_resp();
        total_cnt++;
        if (dbg_state !== 3'd0 || ace.awvalid !== 1'b0)
            $display("FAIL resp_no_accept: state=%0d awvalid=%b want 0/0", dbg_state, ace.awvalid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] op;
            logic [AW-1:0] a;
            op = 2'($urandom_range(0, 2));
            a  = $urandom();
            if (op == 2'd2)
                run_write(a, rand_line(), $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)));
            else
                run_read(op, a, rand_line(), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
            drain_resp();
        end
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b1;
        issue_req(2'd0, 32'h0000_7000, '0);
        ace.arready = 1'b1;
        step();
        ace.arready = 1'b0;
        total_cnt++;
        if (dbg_state !== 3'd2) $display("FAIL mid_in_r: state=%0d want 2", dbg_state);
        else pass_cnt++;
        rst = 1'b1;
        step();
        total_cnt++;
        if ({ace.arvalid, ace.rready, ace.rack, ace.awvalid, ace.wvalid, ace.bready, ace.wack, resp_valid, req_ready} !== 9'd0 ||
            dbg_state !== 3'd0)
            $display("FAIL mid_reset: arv=%b rrdy=%b rack=%b awv=%b wv=%b brdy=%b wack=%b resp_valid=%b req_ready=%b state=%0d want all 0",
                     ace.arvalid, ace.rready, ace.rack, ace.awvalid, ace.wvalid, ace.bready, ace.wack, resp_valid, req_ready, dbg_state);
        else pass_cnt++;
        rst = 1'b0;
        step();
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL mid_release: req_ready=%b want 1", req_ready);
        else pass_cnt++;
        run_read(2'd0, 32'h0000_7040, rand_line(), 4'b0000, 1);
        drain_resp();
    endtask

    task automatic test_reserved_and_snoop();
        resp_ready = 1'b1;
        ax_seen  = 1'b0;
        watch_ax = 1'b1;
        exp_q.push_back({{XW{1'b0}}, 1'b0, 1'b0, 1'b1});
        issue_req(2'd3, 32'h0000_9000, '0);
        total_cnt++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || dbg_state !== 3'd7)
            $display("FAIL reserved_resp: valid=%b err=%b state=%0d want 1/1/7", resp_valid, resp_err, dbg_state);
        else pass_cnt++;
        drain_resp();
        step();
        watch_ax = 1'b0;
        total_cnt++;
        if (ax_seen !== 1'b0) $display("FAIL reserved_no_bus: ax valid seen=%b want 0", ax_seen);
        else pass_cnt++;

        ace.acvalid = 1'b1;
        ace.acaddr  = 32'h0000_0040;
        ace.acsnoop = 4'b1001;
        ace.acprot  = 3'b010;
        snp_crvalid = 1'b1;
        snp_crresp  = 5'b10101;
        snp_acready = 1'b1;
        #1;
        total_cnt++;
        if ({snp_acvalid, snp_acaddr, snp_acsnoop, snp_acprot} !== {1'b1, 32'h0000_0040, 4'b1001, 3'b010})
            $display("FAIL snoop_ac: valid=%b addr=%h snoop=%b prot=%b want 1/00000040/1001/010",
                     snp_acvalid, snp_acaddr, snp_acsnoop, snp_acprot);
        else pass_cnt++;
        total_cnt++;
        if ({ace.crvalid, ace.crresp, ace.acready} !== {1'b1, 5'b10101, 1'b1})
            $display("FAIL snoop_cr: crvalid=%b crresp=%b acready=%b want 1/10101/1", ace.crvalid, ace.crresp, ace.acready);
        else pass_cnt++;
        snp_cdvalid = 1'b1;
        snp_cddata  = rand_line();
        snp_cdlast  = 1'b1;
        ace.crready = 1'b1;
        ace.cdready = 1'b0;
        #1;
        total_cnt++;
        if ({ace.cdvalid, ace.cdlast, snp_crready, snp_cdready} !== 4'b1110 || ace.cddata !== snp_cddata)
            $display("FAIL snoop_cd: cdvalid=%b cdlast=%b crready=%b cdready=%b want 1/1/1/0",
                     ace.cdvalid, ace.cdlast, snp_crready, snp_cdready);
        else pass_cnt++;
    endtask

    initial begin
        ace.awready = 1'b0; ace.wready = 1'b0;
        ace.bvalid = 1'b0; ace.bresp = 2'b00; ace.bid = '0;
        ace.arready = 1'b0;
        ace.rvalid = 1'b0; ace.rdata = '0; ace.rresp = 4'd0; ace.rid = '0; ace.rlast = 1'b0;
        ace.acvalid = 1'b0; ace.acaddr = '0; ace.acsnoop = 4'd0; ace.acprot = 3'd0;
        ace.crready = 1'b0; ace.cdready = 1'b0;

        test_reset();
        test_read_shared();
        test_read_unique_backpressure();
        test_writeback();
        test_resp_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_reserved_and_snoop();

        step();
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_empty: %0d entries left want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
